// File: rtl/param_data_ram_pkg.sv
// Shared definitions for the parametrised data memory.
// Holds op codes, FSM state encodings, the read-capture kind and the
// request error check used by the control logic.
package param_data_ram_pkg;

    localparam logic [2:0] OP_READ  = 3'b000;
    localparam logic [2:0] OP_WRITE = 3'b001;
    localparam logic [2:0] OP_BITRD = 3'b010;
    localparam logic [2:0] OP_BITWR = 3'b011;
    localparam logic [2:0] OP_CLEAR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RMW_WR = 2'b01,
        ST_CLEAR  = 2'b10
    } state_e;

    // Which output register should absorb the RAM read data next cycle.
    typedef enum logic [1:0] {
        RD_NONE = 2'b00,
        RD_WORD = 2'b01,
        RD_BIT  = 2'b10
    } rd_kind_e;

    // A request is rejected for a reserved op, an out-of-range address
    // (CLEAR ignores the address) or an out-of-range bit index (bit ops only).
    function automatic logic op_error(input logic [2:0]  op,
                                      input int unsigned addr,
                                      input int unsigned bsel,
                                      input int unsigned depth,
                                      input int unsigned data_w);
        logic e;
        e = 1'b0;
        case (op)
            OP_READ, OP_WRITE: e = (addr >= depth);
            OP_BITRD, OP_BITWR: e = (addr >= depth) || (bsel >= data_w);
            OP_CLEAR: e = 1'b0;
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ram_array_sp.sv
// Single-port DATA_W x DEPTH storage array.
// Synchronous write; registered read that only updates when re_i is high,
// so the read register holds its word for the following cycle(s).
// No reset: contents and read register power up undefined.
// Ports:
//   clk      clock
//   we_i     write enable
//   re_i     read enable (loads rdata_o on the clock edge)
//   addr_i   shared read/write address
//   wdata_i  write data
//   rdata_o  registered read data
module ram_array_sp #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/param_data_ram.sv
// Parametrised single-port data memory with word/bit access, a whole-memory
// clear sweep and a req/ack handshake with error reporting.
// Ports:
//   clk, reset   clock; asynchronous active-high reset
//   req_i        request strobe, sampled only while busy_o is low
//   op_i         READ/WRITE/BITRD/BITWR/CLEAR (101..111 reserved)
//   addr_i       word address (ignored by CLEAR)
//   bit_sel_i    bit index for BITRD/BITWR
//   wdata_i      word for WRITE
//   wbit_i       bit for BITWR
//   rdata_o      last word read
//   rbit_o       last bit read
//   ack_o        one-cycle completion pulse
//   err_o        error flag, valid with ack_o
//   busy_o       multi-cycle operation (BITWR write-back or CLEAR) in progress
module param_data_ram
    import param_data_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BSEL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_i,
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [BSEL_W-1:0] bit_sel_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              wbit_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rbit_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              busy_o
);

    state_e            state_q, state_d;
    rd_kind_e          rd_kind_q, rd_kind_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BSEL_W-1:0] bsel_q, bsel_d;
    logic              wbit_q, wbit_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rbit_q;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] merged_word;

    ram_array_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // In RMW_WR the RAM read register still holds the word fetched by BITWR,
    // so it doubles as the hold register for the write-back.
    always_comb begin
        merged_word = ram_rdata;
        merged_word[bsel_q] = wbit_q;
    end

    always_comb begin
        state_d   = state_q;
        rd_kind_d = RD_NONE;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        bsel_d    = bsel_q;
        wbit_d    = wbit_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = addr_i;
        ram_wdata = wdata_i;

        unique case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (op_error(op_i, 32'(addr_i), 32'(bit_sel_i), DEPTH, DATA_W)) begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        case (op_i)
                            OP_READ: begin
                                ram_re    = 1'b1;
                                rd_kind_d = RD_WORD;
                                ack_d     = 1'b1;
                            end
                            OP_WRITE: begin
                                ram_we = 1'b1;
                                ack_d  = 1'b1;
                            end
                            OP_BITRD: begin
                                ram_re    = 1'b1;
                                rd_kind_d = RD_BIT;
                                bsel_d    = bit_sel_i;
                                ack_d     = 1'b1;
                            end
                            OP_BITWR: begin
                                ram_re  = 1'b1;
                                addr_d  = addr_i;
                                bsel_d  = bit_sel_i;
                                wbit_d  = wbit_i;
                                state_d = ST_RMW_WR;
                            end
                            OP_CLEAR: begin
                                cnt_d   = '0;
                                state_d = ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_RMW_WR: begin
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = merged_word;
                ack_d     = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = cnt_q;
                ram_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rd_kind_q <= RD_NONE;
            cnt_q     <= '0;
            addr_q    <= '0;
            bsel_q    <= '0;
            wbit_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            rbit_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_kind_q <= rd_kind_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            bsel_q    <= bsel_d;
            wbit_q    <= wbit_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            // Fold the fresh RAM read into the holding registers one cycle on,
            // before the RAM read register can be reused.
            if (rd_kind_q == RD_WORD) begin
                rdata_q <= ram_rdata;
            end
            if (rd_kind_q == RD_BIT) begin
                rbit_q <= ram_rdata[bsel_q];
            end
        end
    end

    // Cycle after a read the new value comes straight from the RAM read
    // register; afterwards it is held locally.
    assign rdata_o = (rd_kind_q == RD_WORD) ? ram_rdata : rdata_q;
    assign rbit_o  = (rd_kind_q == RD_BIT) ? ram_rdata[bsel_q] : rbit_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_param_data_ram.sv
// Self-checking bench for param_data_ram: an 8x32 instance checked against a
// behavioural memory model, plus a 6-bit-wide instance with a wider address
// used for range-error cases.
module tb_param_data_ram;
    import param_data_ram_pkg::*;

    localparam int unsigned DEPTH = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       req, req6;
    logic [2:0] op;
    logic [4:0] addr;
    logic [5:0] addr6;
    logic [2:0] bit_sel;
    logic [7:0] wdata;
    logic [5:0] wdata6;
    logic       wbit;
    logic [7:0] rdata;
    logic [5:0] rdata6;
    logic       rbit, ack, err, busy;
    logic       rbit6, ack6, err6, busy6;

    int nvec = 0;
    int nmis = 0;

    logic [7:0] mm [DEPTH];
    logic [7:0] exp_rdata;
    logic       exp_rbit;

    always #5 clk = ~clk;

    param_data_ram #(.DATA_W(8), .DEPTH(32), .ADDR_W(5), .BSEL_W(3)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req),
        .op_i      (op),
        .addr_i    (addr),
        .bit_sel_i (bit_sel),
        .wdata_i   (wdata),
        .wbit_i    (wbit),
        .rdata_o   (rdata),
        .rbit_o    (rbit),
        .ack_o     (ack),
        .err_o     (err),
        .busy_o    (busy)
    );

    param_data_ram #(.DATA_W(6), .DEPTH(32), .ADDR_W(6), .BSEL_W(3)) u_dut6 (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req6),
        .op_i      (op),
        .addr_i    (addr6),
        .bit_sel_i (bit_sel),
        .wdata_i   (wdata6),
        .wbit_i    (wbit),
        .rdata_o   (rdata6),
        .rbit_o    (rbit6),
        .ack_o     (ack6),
        .err_o     (err6),
        .busy_o    (busy6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the
    // edge that raises ack, so another op may follow back-to-back.
    task automatic do_op8(input logic [2:0] o, input logic [4:0] a, input logic [2:0] b,
                          input logic [7:0] wd, input logic wb, input bit poke);
        logic e;
        int   n;
        e = (o > 3'd4);
        op = o; addr = a; bit_sel = b; wdata = wd; wbit = wb; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        if (!e && o == OP_BITWR) begin
            check("bitwr_busy", 32'(busy), 1);
            check("bitwr_noack", 32'(ack), 0);
            if (poke) begin
                // Must be dropped: the DUT is busy.
                op = OP_WRITE; addr = a ^ 5'd1; wdata = ~wd; req = 1'b1;
            end
            @(posedge clk); #1;
            req = 1'b0;
        end else if (!e && o == OP_CLEAR) begin
            n = 0;
            while (!ack && n < 100) begin
                n++;
                @(posedge clk); #1;
            end
            check("clear_busy_cycles", 32'(n), DEPTH);
        end
        check("ack", 32'(ack), 1);
        check("err", 32'(err), 32'(e));
        check("busy_done", 32'(busy), 0);
        if (!e) begin
            case (o)
                OP_READ:  exp_rdata = mm[a];
                OP_WRITE: mm[a] = wd;
                OP_BITRD: exp_rbit = mm[a][b];
                OP_BITWR: mm[a][b] = wb;
                OP_CLEAR: for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
                default: ;
            endcase
        end
        check("rdata", 32'(rdata), 32'(exp_rdata));
        check("rbit", 32'(rbit), 32'(exp_rbit));
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        check("ack_pulse", 32'(ack), 0);
        check("err_pulse", 32'(err), 0);
        check("busy_idle", 32'(busy), 0);
    endtask

    task automatic do_op6(input logic [2:0] o, input logic [5:0] a, input logic [2:0] b,
                          input logic [5:0] wd, input logic e, input logic [5:0] er,
                          input logic eb);
        op = o; addr6 = a; bit_sel = b; wdata6 = wd; req6 = 1'b1;
        @(posedge clk); #1;
        req6 = 1'b0;
        check("w6_ack", 32'(ack6), 1);
        check("w6_err", 32'(err6), 32'(e));
        check("w6_rdata", 32'(rdata6), 32'(er));
        check("w6_rbit", 32'(rbit6), 32'(eb));
        @(posedge clk); #1;
        check("w6_ack_pulse", 32'(ack6), 0);
    endtask

    initial begin
        logic [2:0] ro;
        reset = 1'b1; req = 1'b0; req6 = 1'b0; op = '0; addr = '0; addr6 = '0;
        bit_sel = '0; wdata = '0; wdata6 = '0; wbit = 1'b0;
        exp_rdata = 8'h00; exp_rbit = 1'b0;
        #1;
        check("rst_rdata", 32'(rdata), 0);
        check("rst_rbit", 32'(rbit), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Write then read-after-write back-to-back.
        do_op8(OP_WRITE, 5'd5, 3'd0, 8'hA5, 1'b0, 1'b0);
        do_op8(OP_READ, 5'd5, 3'd0, 8'h00, 1'b0, 1'b0);
        check("raw_rdata", 32'(rdata), 32'h A5);
        idle_check();

        for (int i = 0; i < DEPTH; i++) do_op8(OP_WRITE, 5'(i), 3'd0, 8'($urandom), 1'b0, 1'b0);

        // Bit write with a request dropped while busy.
        do_op8(OP_WRITE, 5'd3, 3'd0, 8'h0F, 1'b0, 1'b0);
        do_op8(OP_BITWR, 5'd3, 3'd7, 8'h55, 1'b1, 1'b1);
        idle_check();
        do_op8(OP_READ, 5'd3, 3'd0, 8'h00, 1'b0, 1'b0);
        check("bitwr_word", 32'(rdata), 32'h8F);
        do_op8(OP_READ, 5'd2, 3'd0, 8'h00, 1'b0, 1'b0);
        do_op8(OP_BITRD, 5'd3, 3'd0, 8'h00, 1'b0, 1'b0);
        check("bitrd_bit", 32'(rbit), 1);

        // Clear sweep.
        for (int i = 0; i < DEPTH; i++) do_op8(OP_WRITE, 5'(i), 3'd0, 8'hFF, 1'b0, 1'b0);
        do_op8(OP_CLEAR, 5'd9, 3'd0, 8'h00, 1'b0, 1'b0);
        do_op8(OP_READ, 5'd0, 3'd0, 8'h00, 1'b0, 1'b0);
        do_op8(OP_READ, 5'd17, 3'd0, 8'h00, 1'b0, 1'b0);
        do_op8(OP_READ, 5'd31, 3'd0, 8'h00, 1'b0, 1'b0);
        check("clear_word31", 32'(rdata), 0);

        // Reserved ops on the 8-bit instance.
        do_op8(3'b110, 5'd4, 3'd1, 8'h12, 1'b1, 1'b0);
        do_op8(3'b101, 5'd4, 3'd1, 8'h12, 1'b1, 1'b0);
        do_op8(3'b111, 5'd4, 3'd1, 8'h12, 1'b1, 1'b0);
        idle_check();

        // Range errors on the 6-bit-wide, 6-bit-address instance.
        wbit = 1'b0;
        do_op6(OP_WRITE, 6'd2, 3'd0, 6'h2A, 1'b0, 6'h00, 1'b0);
        do_op6(OP_READ, 6'd2, 3'd0, 6'h00, 1'b0, 6'h2A, 1'b0);
        do_op6(OP_BITRD, 6'd2, 3'd1, 6'h00, 1'b0, 6'h2A, 1'b1);
        do_op6(OP_READ, 6'd40, 3'd0, 6'h00, 1'b1, 6'h2A, 1'b1);
        do_op6(OP_BITRD, 6'd2, 3'd6, 6'h00, 1'b1, 6'h2A, 1'b1);
        do_op6(3'b110, 6'd2, 3'd0, 6'h00, 1'b1, 6'h2A, 1'b1);
        do_op6(OP_BITWR, 6'd2, 3'd7, 6'h00, 1'b1, 6'h2A, 1'b1);
        do_op6(OP_BITRD, 6'd33, 3'd0, 6'h00, 1'b1, 6'h2A, 1'b1);
        do_op6(OP_WRITE, 6'd40, 3'd0, 6'h15, 1'b1, 6'h2A, 1'b1);
        do_op6(OP_READ, 6'd2, 3'd0, 6'h00, 1'b0, 6'h2A, 1'b1);
        do_op6(OP_BITRD, 6'd2, 3'd0, 6'h00, 1'b0, 6'h2A, 1'b0);

        // Reset in the middle of a clear sweep: 9 words done, rest untouched.
        for (int i = 0; i < DEPTH; i++) do_op8(OP_WRITE, 5'(i), 3'd0, 8'($urandom), 1'b0, 1'b0);
        do_op8(OP_READ, 5'd30, 3'd0, 8'h00, 1'b0, 1'b0);
        op = OP_CLEAR; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ack", 32'(ack), 0);
        check("midrst_rdata", 32'(rdata), 0);
        check("midrst_rbit", 32'(rbit), 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_ack_after", 32'(ack), 0);
        for (int i = 0; i < 9; i++) mm[i] = 8'h00;
        exp_rdata = 8'h00; exp_rbit = 1'b0;
        for (int i = 0; i < DEPTH; i++) do_op8(OP_READ, 5'(i), 3'd0, 8'h00, 1'b0, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            ro = 3'($urandom_range(0, 7));
            if (ro == OP_CLEAR && $urandom_range(0, 3) != 0) ro = OP_READ;
            do_op8(ro, 5'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/param_data_ram.md
Name: param_data_ram

Overview:
Parametrised single-port data memory for the instruction-list processor. It replaces the fixed byte RAM with a configurable width and depth. It adds bit-level read and bit-level write (read-modify-write), a whole-memory clear sweep, a req/ack handshake and error reporting. It sits between the execute stage and the processor's byte/bit operand storage.

Parameters:
DATA_W, 8, word width in bits (>=2)
DEPTH, 32, number of words (2..2^ADDR_W)
ADDR_W, 5, address width
BSEL_W, 3, bit-select width (2^BSEL_W >= DATA_W)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req  in  1  request strobe, sampled only when busy=0
op  in  3  operation code: 000 READ, 001 WRITE, 010 BITRD, 011 BITWR, 100 CLEAR, 101-111 reserved
addr  in  ADDR_W  word address
bit_sel  in  BSEL_W  bit index for BITRD/BITWR
wdata  in  DATA_W  write word for WRITE
wbit  in  1  write bit for BITWR
rdata  out  DATA_W  last word read, registered
rbit  out  1  last bit read, registered
ack  out  1  one-cycle completion pulse, registered
err  out  1  error flag, valid with ack, registered
busy  out  1  multi-cycle operation in progress, registered (state != IDLE)

Behaviour:
- Clock and reset: clk is the clock. reset is asynchronous, active-high.
- Reset values: rdata=0, rbit=0, ack=0, err=0, busy=0, state=IDLE, clear counter=0. Memory contents are not reset.
- States: IDLE, RMW_WR, CLEAR.
- req is accepted at edge N when busy=0. While busy=1, req is dropped: no ack, not queued.
- READ: edge N latches rdata<=mem[addr]. ack=1 in cycle N+1. Latency 1.
- WRITE: edge N writes mem[addr]<=wdata. ack in cycle N+1.
- BITRD: edge N latches rbit<=mem[addr][bit_sel]. ack in N+1. rdata is unchanged.
- BITWR:
  - Edge N latches the word into the hold register and captures addr, bit_sel and wbit. State goes to RMW_WR; busy=1 in N+1.
  - Edge N+1 writes the hold word with bit bit_sel replaced by wbit. ack=1 and busy=0 in N+2. Latency 2.
  - Other bits of the word are unchanged.
- CLEAR:
  - Edge N moves to CLEAR with counter=0; busy=1 from N+1.
  - Each cycle in CLEAR writes mem[counter]<=0 and increments the counter.
  - On the write of DEPTH-1 the state returns to IDLE. ack=1 and busy=0 in cycle N+1+DEPTH.
  - addr is ignored for CLEAR.
- Errors: each of the following gives ack=1 and err=1 in N+1, with no memory access and no output or state change.
  - Reserved op.
  - addr >= DEPTH (all ops except CLEAR).
  - bit_sel >= DATA_W (BITRD/BITWR).
- err=0 on every successful ack.
- ack and err are single-cycle pulses and are 0 in all other cycles.
- rdata and rbit hold their value until the next successful READ or BITRD. They are never tri-stated.
- Read-after-write: a WRITE at edge N followed by a READ of the same address at edge N+1 returns the new data.
- Reset mid-operation (RMW_WR or CLEAR) returns to IDLE immediately with no ack.
  - A partially done CLEAR leaves words below the counter zeroed and the rest untouched.
  - An interrupted BITWR performs no write.

Decomposition:
- Package param_data_ram_pkg holds:
  - op code localparams OP_READ..OP_CLEAR;
  - state encodings ST_IDLE, ST_RMW_WR, ST_CLEAR;
  - the error-condition helper function.
- One sub-module, ram_array_sp: DATA_W x DEPTH storage with synchronous write and registered read port. It has no reset.
- FSM, hold register, counter and handshake logic live in param_data_ram.

Test Plan:
1. DATA_W=8, DEPTH=32: WRITE addr=5 wdata=8'hA5, then READ addr=5 next cycle -> ack each op one cycle after request; rdata=8'hA5, err=0.
2. mem[3]=8'h0F, BITWR addr=3 bit_sel=7 wbit=1 -> busy high one cycle; ack at N+2; READ addr=3 gives 8'h8F. A req issued during busy gets no ack.
3. BITRD addr=3 bit_sel=0 -> rbit=1, rdata unchanged, ack at N+1.
4. Fill all 32 words with 8'hFF, CLEAR -> busy for 32 cycles, ack at N+33; READ of addr 0, 17 and 31 returns 8'h00.
5. READ addr=40 (DEPTH=32); BITRD bit_sel=... with DATA_W=6, bit_sel=6; op=3'b110 -> each gives ack=1, err=1, and rdata/rbit/memory unchanged.
6. Assert reset at cycle 10 of a CLEAR -> outputs zero immediately, no ack. Words 0..8 read as 0 and words 9..31 keep their old values after reset.
